// File: rtl/bram_sp_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port block RAM.
// A tag pipeline routes each read's douta back to the requester that issued it.
module bram_sp_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WE_W   = DATA_W / 8,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,

  input  logic              a_req,
  input  logic [WE_W-1:0]   a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic [WE_W-1:0]   b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_ena,
  output logic [WE_W-1:0]   mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic              mem_rsta,
  input  logic [DATA_W-1:0] mem_douta
);

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

  req_id_t         last;
  logic [RD_LAT:0] tag_valid;
  logic [RD_LAT:0] tag_id;
  logic            ins_valid;
  logic            ins_id;
  logic            head_a;
  logic            head_b;

  // The requester that did not win last time has priority when both ask.
  assign a_gnt = !rsta && a_req && (!b_req || last == ID_B);
  assign b_gnt = !rsta && b_req && (!a_req || last == ID_A);

  assign mem_rsta = rsta;

  assign ins_valid = (a_gnt && a_we == '0) || (b_gnt && b_we == '0);
  assign ins_id    = b_gnt;

  // Stage RD_LAT holds the read whose douta is valid during this cycle.
  assign head_a = tag_valid[RD_LAT] && !tag_id[RD_LAT];
  assign head_b = tag_valid[RD_LAT] &&  tag_id[RD_LAT];

  always_ff @(posedge clka) begin
    if (rsta) begin
      last      <= ID_A;
      mem_ena   <= 1'b0;
      mem_wea   <= '0;
      mem_addra <= '0;
      mem_dina  <= '0;
      tag_valid <= '0;
      tag_id    <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      mem_ena <= a_gnt || b_gnt;
      mem_wea <= '0;
      if (a_gnt) begin
        last      <= ID_A;
        mem_wea   <= a_we;
        mem_addra <= a_addr;
        mem_dina  <= a_wdata;
      end else if (b_gnt) begin
        last      <= ID_B;
        mem_wea   <= b_we;
        mem_addra <= b_addr;
        mem_dina  <= b_wdata;
      end

      tag_valid <= {tag_valid[RD_LAT-1:0], ins_valid};
      tag_id    <= {tag_id[RD_LAT-1:0], ins_id};

      a_rvalid <= head_a;
      b_rvalid <= head_b;
      if (head_a) a_rdata <= mem_douta;
      if (head_b) b_rdata <= mem_douta;
    end
  end

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Self-checking bench for bram_sp_arbiter: behavioural RAM, shadow memory and
// an in-order response scoreboard checked on the falling edge.
module tb_bram_sp_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;
  localparam int RD_LAT = 1;

  logic              clka = 1'b0;
  logic              rsta = 1'b1;

  logic              a_req = 1'b0;
  logic [WE_W-1:0]   a_we = '0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req = 1'b0;
  logic [WE_W-1:0]   b_we = '0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_ena;
  logic [WE_W-1:0]   mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic              mem_rsta;
  logic [DATA_W-1:0] mem_douta = '0;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rsp_t;

  rsp_t sb[$];
  logic grant_log[$];
  int   xfer_log[$];

  logic [DATA_W-1:0] ram     [64];
  logic [DATA_W-1:0] ref_mem [64];

  logic [WE_W-1:0]   a_cmd_we    [64];
  logic [ADDR_W-1:0] a_cmd_addr  [64];
  logic [DATA_W-1:0] a_cmd_wdata [64];
  logic [WE_W-1:0]   b_cmd_we    [64];
  logic [ADDR_W-1:0] b_cmd_addr  [64];
  logic [DATA_W-1:0] b_cmd_wdata [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_wr = 0;
  int a_rd = 0;
  int b_wr = 0;
  int b_rd = 0;
  int ena_count = 0;

  logic              exp_ena = 1'b0;
  logic [WE_W-1:0]   exp_wea = '0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_din = '0;
  logic              p_id;
  logic [WE_W-1:0]   p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  rsp_t              mon_e;

  bram_sp_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WE_W  (WE_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clka     (clka),
    .rsta     (rsta),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_ena  (mem_ena),
    .mem_wea  (mem_wea),
    .mem_addra(mem_addra),
    .mem_dina (mem_dina),
    .mem_rsta (mem_rsta),
    .mem_douta(mem_douta)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  // Single-port RAM: douta updates on the edge that samples ena.
  always @(posedge clka) begin
    if (mem_ena) begin
      for (int i = 0; i < WE_W; i++)
        if (mem_wea[i]) ram[mem_addra[7:2]][8*i +: 8] <= mem_dina[8*i +: 8];
      mem_douta <= ram[mem_addra[7:2]];
    end
  end

  // Each requester presents the head of its command list until it transfers.
  always @(posedge clka) begin
    #1;
    if (a_rd < a_wr) begin
      a_req = 1'b1; a_we = a_cmd_we[a_rd]; a_addr = a_cmd_addr[a_rd]; a_wdata = a_cmd_wdata[a_rd];
    end else begin
      a_req = 1'b0; a_we = '0;
    end
    if (b_rd < b_wr) begin
      b_req = 1'b1; b_we = b_cmd_we[b_rd]; b_addr = b_cmd_addr[b_rd]; b_wdata = b_cmd_wdata[b_rd];
    end else begin
      b_req = 1'b0; b_we = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [WE_W-1:0] we,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (id) begin
      b_cmd_we[b_wr] = we; b_cmd_addr[b_wr] = addr; b_cmd_wdata[b_wr] = wdata; b_wr++;
    end else begin
      a_cmd_we[a_wr] = we; a_cmd_addr[a_wr] = addr; a_cmd_wdata[a_wr] = wdata; a_wr++;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(a_rd == a_wr && b_rd == b_wr && sb.size() == 0) && n < 200) begin
      @(negedge clka);
      n++;
    end
    checkOutput("idle_timeout", 64'(n >= 200), 64'd0);
    repeat (4) @(negedge clka);
  endtask

  // Monitor: checks last edge's RAM drive and responses, then predicts the next edge.
  always @(negedge clka) begin
    checkOutput("mem_rsta", 64'(mem_rsta), 64'(rsta));
    checkOutput("mem_ena", 64'(mem_ena), 64'(exp_ena));
    if (exp_ena) begin
      checkOutput("mem_wea", 64'(mem_wea), 64'(exp_wea));
      checkOutput("mem_addra", 64'(mem_addra), 64'(exp_addr));
      checkOutput("mem_dina", 64'(mem_dina), 64'(exp_din));
    end else begin
      checkOutput("mem_wea_idle", 64'(mem_wea), 64'd0);
    end
    if (mem_ena) ena_count++;

    if (rsta) checkOutput("gnt_in_reset", 64'({a_gnt, b_gnt}), 64'd0);
    else checkOutput("gnt_both", 64'({a_gnt, b_gnt} == 2'b11), 64'd0);

    if (a_rvalid || b_rvalid || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      if (sb.size() == 0) begin
        checkOutput("rvalid_spurious", 64'({a_rvalid, b_rvalid}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_strobe", 64'({a_rvalid, b_rvalid}), mon_e.id ? 64'd1 : 64'd2);
        checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
        checkOutput("rsp_data", 64'(mon_e.id ? b_rdata : a_rdata), 64'(mon_e.data));
      end
    end

    exp_ena = 1'b0;
    if (a_gnt || b_gnt) begin
      p_id    = b_gnt;
      p_we    = b_gnt ? b_we : a_we;
      p_addr  = b_gnt ? b_addr : a_addr;
      p_wdata = b_gnt ? b_wdata : a_wdata;
      exp_ena  = 1'b1;
      exp_wea  = p_we;
      exp_addr = p_addr;
      exp_din  = p_wdata;
      grant_log.push_back(p_id);
      xfer_log.push_back(cyc + 1);
      if (p_id) b_rd++;
      else a_rd++;
      if (p_we == '0) begin
        sb.push_back('{p_id, ref_mem[p_addr[7:2]], cyc + 2 + RD_LAT});
      end else begin
        for (int i = 0; i < WE_W; i++)
          if (p_we[i]) ref_mem[p_addr[7:2]][8*i +: 8] = p_wdata[8*i +: 8];
      end
    end

    // Reads whose response edge falls at or after a reset edge are lost.
    if (rsta) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc >= cyc + 1) sb.delete(i);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    int n0;
    int g0;
    int n;

    for (int i = 0; i < 64; i++) begin
      ram[i]     = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end

    // Reset held for 10 cycles with A already requesting a write.
    applyStimulus(1'b0, 4'hF, 32'h0, 32'h5555_5555);
    repeat (10) @(posedge clka);
    @(negedge clka);
    checkOutput("rst_a_gnt", 64'(a_gnt), 64'd0);
    checkOutput("rst_mem_ena", 64'(mem_ena), 64'd0);
    checkOutput("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    e0 = ena_count;
    @(posedge clka);
    #1 rsta = 1'b0;
    @(negedge clka);
    checkOutput("gnt_after_reset", 64'(a_gnt), 64'd1);

    // Write then read of address 0.
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    waitIdle();
    checkOutput("wr_rd_ena_cycles", 64'(ena_count - e0), 64'd2);
    checkOutput("wr_rd_rdata", 64'(a_rdata), 64'h5555_5555);

    // Eight back-to-back reads from A alone.
    e0 = ena_count;
    n0 = xfer_log.size();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'h0, 32'(4 * i), 32'h0);
    waitIdle();
    checkOutput("b2b_ena_cycles", 64'(ena_count - e0), 64'd8);
    checkOutput("b2b_xfer_count", 64'(xfer_log.size() - n0), 64'd8);
    if (xfer_log.size() >= n0 + 8)
      checkOutput("b2b_span", 64'(xfer_log[n0 + 7] - xfer_log[n0]), 64'd7);
    checkOutput("b2b_last_rdata", 64'(a_rdata), 64'hA500_0007);

    // Partial byte-mask write merges with existing contents.
    applyStimulus(1'b0, 4'hF, 32'h10, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 4'b0011, 32'h10, 32'h0000_1234);
    applyStimulus(1'b0, 4'h0, 32'h10, 32'h0);
    waitIdle();
    checkOutput("mask_rdata", 64'(a_rdata), 64'hFFFF_1234);

    // B read in flight when reset arrives: its response must never appear.
    applyStimulus(1'b1, 4'h0, 32'h3C, 32'h0);
    n = 0;
    while (!b_gnt && n < 50) begin
      @(negedge clka);
      n++;
    end
    checkOutput("midflight_gnt_timeout", 64'(b_gnt), 64'd1);
    @(posedge clka);
    #1 rsta = 1'b1;
    repeat (3) @(negedge clka);
    checkOutput("rst2_mem_ena", 64'(mem_ena), 64'd0);
    checkOutput("rst2_mem_wea", 64'(mem_wea), 64'd0);
    checkOutput("rst2_mem_addra", 64'(mem_addra), 64'd0);
    checkOutput("rst2_mem_dina", 64'(mem_dina), 64'd0);
    checkOutput("rst2_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    checkOutput("rst2_a_rdata", 64'(a_rdata), 64'd0);
    checkOutput("rst2_b_rdata", 64'(b_rdata), 64'd0);

    // Both requesters held from reset release: grants alternate starting with B.
    g0 = grant_log.size();
    applyStimulus(1'b0, 4'h0, 32'h20, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h24, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h28, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h2C, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h30, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h34, 32'h0);
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
    waitIdle();
    checkOutput("contention_count", 64'(grant_log.size() - g0), 64'd6);
    for (int i = 0; i < 6; i++)
      if (g0 + i < grant_log.size())
        checkOutput("contention_order", 64'(grant_log[g0 + i]), (i % 2 == 0) ? 64'd1 : 64'd0);
    checkOutput("contention_a_rdata", 64'(a_rdata), 64'hA500_000A);
    checkOutput("contention_b_rdata", 64'(b_rdata), 64'hA500_000D);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
